// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
//
// Conditions a raw, bouncing, asynchronous push-button for the LED blinker
// path. The button is synchronized into the clk domain and debounced with a
// consecutive-sample counter. The result is a clean level, one-cycle
// press/release pulses, a once-per-press long-press pulse and a press-toggled
// enable.
//
// Parameters:
//   STABLE_CYCLES  consecutive cycles the synchronized input must hold a new
//                  value before btn_level follows (>= 1)
//   LONG_CYCLES    cycles btn_level must stay high after a press before
//                  btn_long fires (>= 2)
//
// Ports:
//   clk          in   system clock, all logic on posedge
//   rst_n        in   asynchronous active-low reset
//   btn_raw      in   raw button, asynchronous to clk, active-high
//   btn_level    out  debounced, registered button level
//   btn_press    out  one-cycle pulse after btn_level rises
//   btn_release  out  one-cycle pulse after btn_level falls
//   btn_long     out  one-cycle pulse, once per press, after LONG_CYCLES of
//                     continuous high level
//   btn_toggle   out  inverts on every press; run/hold enable for the blinker
// ---------------------------------------------------------------------------
module btn_debounce #(
    parameter int STABLE_CYCLES = 1000000,
    parameter int LONG_CYCLES   = 100000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long,
    output logic btn_toggle
);

    localparam int STABLE_W = $clog2(STABLE_CYCLES + 1);
    localparam int LONG_W   = $clog2(LONG_CYCLES + 1);

    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);
    localparam logic [LONG_W-1:0]   LONG_MAX    = LONG_W'(LONG_CYCLES);
    localparam logic [LONG_W-1:0]   LONG_PRE    = LONG_W'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        RISE_WAIT = 2'd1,
        HIGH      = 2'd2,
        FALL_WAIT = 2'd3
    } state_t;

    logic                sync1;
    logic                btn_sync;
    state_t              state;
    logic [STABLE_W-1:0] stable_cnt;
    logic [LONG_W-1:0]   hold_cnt;

    // Two-flop synchronizer; only btn_sync is used past this point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            sync1    <= btn_raw;
            btn_sync <= sync1;
        end
    end

    // Debounce FSM. The counter counts consecutive cycles in which btn_sync
    // disagrees with btn_level; any agreeing cycle restarts qualification.
    // When STABLE_CYCLES is 1, STABLE_LAST is 0 so the first disagreeing
    // sample commits immediately and the WAIT states are never entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOW;
            stable_cnt  <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_toggle  <= 1'b0;
        end else begin
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            case (state)
                LOW, RISE_WAIT: begin
                    if (!btn_sync) begin
                        state      <= LOW;
                        stable_cnt <= '0;
                    end else if (stable_cnt == STABLE_LAST) begin
                        state      <= HIGH;
                        stable_cnt <= '0;
                        btn_level  <= 1'b1;
                        btn_press  <= 1'b1;
                        btn_toggle <= ~btn_toggle;
                    end else begin
                        state      <= RISE_WAIT;
                        stable_cnt <= stable_cnt + STABLE_W'(1);
                    end
                end
                HIGH, FALL_WAIT: begin
                    if (btn_sync) begin
                        state      <= HIGH;
                        stable_cnt <= '0;
                    end else if (stable_cnt == STABLE_LAST) begin
                        state       <= LOW;
                        stable_cnt  <= '0;
                        btn_level   <= 1'b0;
                        btn_release <= 1'b1;
                    end else begin
                        state      <= FALL_WAIT;
                        stable_cnt <= stable_cnt + STABLE_W'(1);
                    end
                end
                default: begin
                    state      <= LOW;
                    stable_cnt <= '0;
                end
            endcase
        end
    end

    // Hold counter: runs only while the debounced level is high and sticks
    // at LONG_MAX, so btn_long can fire at most once per press. It looks at
    // the pre-edge level, so the edge on which level falls still counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            btn_long <= 1'b0;
        end else begin
            if (!btn_level) begin
                hold_cnt <= '0;
            end else if (hold_cnt != LONG_MAX) begin
                hold_cnt <= hold_cnt + LONG_W'(1);
            end
            btn_long <= btn_level && (hold_cnt == LONG_PRE);
        end
    end

endmodule

// File: tb/tb_btn_debounce.sv
// ---------------------------------------------------------------------------
// tb_btn_debounce
//
// Bench for btn_debounce with STABLE_CYCLES=4, LONG_CYCLES=10. A reference
// model tracks the expected outputs from the button's input history. The
// model qualifies a new level when the last STABLE synchronized samples all
// disagree with the current level. It fires the long pulse LONG edges after
// the most recent rise. Directed scenarios carry literal expectations, and
// a randomized section with occasional resets follows them.
// ---------------------------------------------------------------------------
module tb_btn_debounce;

    localparam int STABLE = 4;
    localparam int LONG   = 10;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic btn_raw = 1'b0;
    logic btn_level, btn_press, btn_release, btn_long, btn_toggle;

    int vectors     = 0;
    int miscompares = 0;
    bit compare_en  = 1'b0;

    btn_debounce #(
        .STABLE_CYCLES(STABLE),
        .LONG_CYCLES  (LONG)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long),
        .btn_toggle (btn_toggle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. raw_q holds btn_raw as sampled on edges 1..n since
    // reset; the synchronized value seen just before edge k is the raw
    // sample from edge k-2.
    // ------------------------------------------------------------------
    int n;
    int last_flip;
    int last_rise;
    bit raw_q[$];
    bit m_level, m_press, m_release, m_long, m_toggle;

    function automatic bit sync_before(input int k);
        if (k >= 3) return raw_q[k-3];
        return 1'b0;
    endfunction

    task automatic model_reset();
        n         = 0;
        last_flip = -1000;
        last_rise = -1000;
        raw_q.delete();
        m_level   = 1'b0;
        m_press   = 1'b0;
        m_release = 1'b0;
        m_long    = 1'b0;
        m_toggle  = 1'b0;
    endtask

    task automatic model_step();
        bit flip;
        bit lvl_b;
        n++;
        raw_q.push_back(btn_raw);
        lvl_b = m_level;
        flip  = (n >= STABLE) && (n - last_flip >= STABLE);
        for (int j = 0; j < STABLE; j++)
            if (sync_before(n - j) == lvl_b) flip = 1'b0;
        m_long    = lvl_b && (n - last_rise == LONG);
        m_press   = flip && !lvl_b;
        m_release = flip && lvl_b;
        if (flip) begin
            m_level   = !lvl_b;
            last_flip = n;
        end
        if (m_press) begin
            m_toggle  = !m_toggle;
            last_rise = n;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (compare_en)
                chk("outputs{level,press,release,long,toggle}",
                    {27'd0, btn_level, btn_press, btn_release, btn_long, btn_toggle},
                    {27'd0, m_level, m_press, m_release, m_long, m_toggle});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // Press with btn_raw held high out of reset: rise at posedge 6, long at 16.
    task automatic check_from_reset_release(input string tag, input logic exp_toggle);
        for (int p = 1; p <= 17; p++) begin
            @(posedge clk);
            #1;
            if (p == 5)  chk({tag, "_level_before"}, btn_level, 1'b0);
            if (p == 6) begin
                chk({tag, "_level_rise"}, btn_level, 1'b1);
                chk({tag, "_press"}, btn_press, 1'b1);
                chk({tag, "_toggle"}, btn_toggle, exp_toggle);
            end
            if (p == 7)  chk({tag, "_press_end"}, btn_press, 1'b0);
            if (p == 15) chk({tag, "_long_early"}, btn_long, 1'b0);
            if (p == 16) chk({tag, "_long"}, btn_long, 1'b1);
            if (p == 17) chk({tag, "_long_once"}, btn_long, 1'b0);
        end
    endtask

    // Drive btn_raw high before the next edge and expect the rise 6 edges on.
    task automatic press_and_check(input string tag, input logic exp_toggle);
        @(negedge clk);
        btn_raw = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk({tag, "_level_before"}, btn_level, 1'b0);
        @(posedge clk);
        #1;
        chk({tag, "_level"}, btn_level, 1'b1);
        chk({tag, "_press"}, btn_press, 1'b1);
        chk({tag, "_release"}, btn_release, 1'b0);
        chk({tag, "_toggle"}, btn_toggle, exp_toggle);
    endtask

    initial begin
        // Reset held with the button pressed.
        btn_raw    = 1'b1;
        rst_n      = 1'b0;
        compare_en = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", {27'd0, btn_level, btn_press, btn_release, btn_long, btn_toggle}, 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        check_from_reset_release("reset_press", 1'b1);

        // Keep holding: no second long pulse, then release.
        repeat (30) @(negedge clk);
        btn_raw = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("long_release", btn_release, 1'b1);
        chk("long_release_level", btn_level, 1'b0);
        chk("long_release_toggle", btn_toggle, 1'b1);
        repeat (5) @(negedge clk);

        // Clean press, held briefly, released.
        press_and_check("clean", 1'b0);
        repeat (3) @(negedge clk);
        btn_raw = 1'b0;
        repeat (12) @(negedge clk);

        // Bounce for 8 cycles, then hold high.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            btn_raw = (i % 2 == 0);
        end
        press_and_check("bounce", 1'b1);
        @(negedge clk);
        btn_raw = 1'b0;
        repeat (14) @(negedge clk);

        // Two short presses of 6 qualified cycles: no long pulse.
        press_and_check("short1", 1'b0);
        @(negedge clk);
        btn_raw = 1'b0;
        repeat (14) @(negedge clk);
        press_and_check("short2", 1'b1);
        @(negedge clk);
        btn_raw = 1'b0;
        repeat (14) @(negedge clk);
        chk("short_toggle_final", btn_toggle, 1'b1);

        // Reset asserted while the hold count is 7.
        press_and_check("mid", 1'b0);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_async", {27'd0, btn_level, btn_press, btn_release, btn_long, btn_toggle}, 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        check_from_reset_release("after_reset", 1'b1);
        @(negedge clk);
        btn_raw = 1'b0;
        repeat (12) @(negedge clk);

        // Randomized runs, including long holds and occasional resets.
        for (int r = 0; r < 250; r++) begin
            int len;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 30) : $urandom_range(1, 6);
            @(negedge clk);
            btn_raw = $urandom_range(0, 1);
            repeat (len - 1) @(negedge clk);
            if ($urandom_range(0, 39) == 0) begin
                #2;
                rst_n = 1'b0;
                @(negedge clk);
                #2;
                rst_n = 1'b1;
            end
        end

        repeat (3) @(negedge clk);
        compare_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
